ula_seq: RTL
============

# ula_seq

Registered, parametrised successor to the 2-bit combinational ULA on the board top. It takes NBITS-wide operands with a start/done handshake, registers the result and a set of status flags, and adds a multi-cycle shift-add multiply on the previously unused opcode 011. It sits between the switch/register front end and the LCD/LED result path. One operation is in flight at a time.

## Interface
- NBITS, default 8, operand and result width (≥2)
- clk_2  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high; clears all state and outputs
- start  in  1  request; sampled only when busy=0
- a  in  NBITS  operand A, captured on accepted start
- b  in  NBITS  operand B, captured on accepted start
- f  in  3  opcode, captured on accepted start
- busy  out  1  multiply in progress; start ignored
- done  out  1  one-cycle pulse; y and flags are newly valid
- y  out  NBITS  result, held until the next done
- zero  out  1  y == 0
- neg  out  1  y[NBITS-1]
- carry  out  1  add carry-out / sub borrow / multiply high-half nonzero
- ovf  out  1  signed overflow (add/sub only)
- err  out  1  unsupported opcode on the last completed operation

## Operation
- Opcodes:
  - 000 a&b
  - 001 a|b
  - 010 a+b
  - 011 a*b (low NBITS)
  - 100 a&~b
  - 101 a|~b
  - 110 a−b
  - 111 unsigned a<b, zero-extended to NBITS
- States:
  - IDLE: busy=0, done=0.
  - MUL: busy=1.
  - DONE: busy=0, done=1 for exactly one cycle.
- Transitions:
  - IDLE→DONE on start with f≠011. Result and flags are computed from the inputs and registered at that edge.
  - IDLE→MUL on start with f=011. Capture a, b. Clear the 2·NBITS product accumulator and the iteration counter.
  - MUL: each cycle, if the multiplier LSB is 1, add the multiplicand to the accumulator. Then shift the multiplicand left and the multiplier right, and increment the counter. After NBITS iterations → DONE, with y = product[NBITS-1:0] and carry = |product[2NBITS-1:NBITS].
  - DONE→IDLE when start=0. DONE behaves as IDLE for start: a new start is accepted in DONE, giving back-to-back operations.
- Arithmetic rules:
  - add: carry = bit NBITS of the (NBITS+1)-bit sum. ovf = (a[MSB]==b[MSB]) && (y[MSB]≠a[MSB]).
  - sub: carry = borrow (a<b unsigned). ovf = (a[MSB]≠b[MSB]) && (y[MSB]≠a[MSB]).
  - Logic ops and 111: carry=0, ovf=0.
  - multiply: ovf=0.
- Flags:
  - zero and neg derive from the registered y for every opcode.
  - y and flags change only at done. They hold their values across IDLE.
- err:
  - Set only for 011 when multiply is compiled out, otherwise 0.
  - Updated at every done.
- Inputs a, b, f may change freely after the accepted start edge. Captured copies are used.

## Timing
- Reset values: busy=0, done=0, y=0, zero=1, neg=0, carry=0, ovf=0, err=0. State is IDLE, and the accumulator and counter are cleared.
- Single-cycle ops: start accepted at edge t; done=1 during the cycle following edge t (latency 1).
- Multiply: busy=1 for NBITS cycles after the accepting edge. done is asserted NBITS+1 cycles after the accepting edge.
- start while busy=1 is ignored and not queued. start held high gives continuous back-to-back operations: one per cycle for single-cycle ops, one per NBITS+1 cycles for multiply.
- reset asserted mid-multiply: immediate return to reset values. No done is produced for the aborted operation.

## Configuration
- ULA_MUL_EN defined: opcode 011 runs the shift-add multiplier described above.
- ULA_MUL_EN undefined: no multiplier datapath, accumulator or counter, and the MUL state is absent. Opcode 011 completes with latency 1, y=0, all arithmetic flags 0, zero=1, err=1. busy is tied to 0.

## Test plan
- Add, NBITS=8: 200+100 → y=44, carry=1, ovf=0, zero=0, done one cycle after start. Then 0x7F+0x01 → y=0x80, ovf=1, neg=1, carry=0.
- Sub and compare: 5−7 → y=0xFE, carry=1, neg=1, ovf=0. Then f=111 with a=3, b=9 → y=1, carry=0. Then a=9, b=3 → y=0, zero=1.
- Multiply (ULA_MUL_EN): 13*11 → y=0x8F, carry=0, busy high 8 cycles, done 9 cycles after start. 16*16 → y=0, zero=1, carry=1.
- Handshake: start pulsed during busy is ignored and the result matches the first operation. start held high across a DONE cycle → back-to-back add results on consecutive cycles. Inputs changed after acceptance do not affect the result.
- Reset: assert reset 3 cycles into a multiply → all outputs at reset values immediately. No done appears after release. A following add completes normally.
- Without ULA_MUL_EN: f=011 with a=5, b=5 → done after 1 cycle, y=0, err=1, busy never high. A next add clears err.

Source files
------------

// File: rtl/ula_seq.sv
// Registered NBITS-wide ULA with start/done handshake and status flags.
// Define ULA_MUL_EN to build the multi-cycle shift-add multiplier on opcode 011.
module ula_seq #(
  parameter int NBITS = 8
) (
  input  logic             clk_2,
  input  logic             reset,
  input  logic             start,
  input  logic [NBITS-1:0] a,
  input  logic [NBITS-1:0] b,
  input  logic [2:0]       f,
  output logic             busy,
  output logic             done,
  output logic [NBITS-1:0] y,
  output logic             zero,
  output logic             neg,
  output logic             carry,
  output logic             ovf,
  output logic             err
);

  localparam int MSB = NBITS - 1;

`ifdef ULA_MUL_EN
  localparam logic MUL_OFF = 1'b0;
  localparam int   CW      = $clog2(NBITS);
  // State bits double as the done/busy flops.
  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_DONE = 2'b01,
    S_MUL  = 2'b10
  } state_t;
`else
  localparam logic MUL_OFF = 1'b1;
  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_DONE = 1'b1
  } state_t;
`endif

  state_t state;

  assign done = state[0];
`ifdef ULA_MUL_EN
  assign busy = state[1];
`else
  assign busy = 1'b0;
`endif

  logic [NBITS:0]   sum;
  logic [NBITS:0]   diff;
  logic [NBITS-1:0] alu_y;
  logic             alu_c;
  logic             alu_o;
  logic             alu_e;

  always_comb begin
    sum   = {1'b0, a} + {1'b0, b};
    diff  = {1'b0, a} - {1'b0, b};
    alu_y = '0;
    alu_c = 1'b0;
    alu_o = 1'b0;
    alu_e = 1'b0;
    case (f)
      3'b000: alu_y = a & b;
      3'b001: alu_y = a | b;
      3'b010: begin
        alu_y = sum[NBITS-1:0];
        alu_c = sum[NBITS];
        alu_o = (a[MSB] == b[MSB]) && (sum[MSB] != a[MSB]);
      end
      3'b011: alu_e = MUL_OFF;
      3'b100: alu_y = a & ~b;
      3'b101: alu_y = a | ~b;
      3'b110: begin
        alu_y = diff[NBITS-1:0];
        alu_c = diff[NBITS];
        alu_o = (a[MSB] != b[MSB]) && (diff[MSB] != a[MSB]);
      end
      default: alu_y = {{(NBITS-1){1'b0}}, (a < b)};
    endcase
  end

`ifdef ULA_MUL_EN
  logic [2*NBITS-1:0] acc;
  logic [2*NBITS-1:0] acc_nx;
  logic [2*NBITS-1:0] mcand;
  logic [NBITS-1:0]   mplier;
  logic [CW-1:0]      cnt;

  always_comb begin
    acc_nx = acc;
    if (mplier[0]) acc_nx = acc + mcand;
  end
`endif

  always_ff @(posedge clk_2 or posedge reset) begin
    if (reset) begin
      state <= S_IDLE;
      y     <= '0;
      zero  <= 1'b1;
      neg   <= 1'b0;
      carry <= 1'b0;
      ovf   <= 1'b0;
      err   <= 1'b0;
`ifdef ULA_MUL_EN
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
      cnt    <= '0;
`endif
    end else begin
`ifdef ULA_MUL_EN
      if (state == S_MUL) begin
        acc    <= acc_nx;
        mcand  <= mcand << 1;
        mplier <= mplier >> 1;
        cnt    <= cnt + 1'b1;
        if (cnt == CW'(NBITS - 1)) begin
          state <= S_DONE;
          y     <= acc_nx[NBITS-1:0];
          zero  <= (acc_nx[NBITS-1:0] == '0);
          neg   <= acc_nx[MSB];
          carry <= |acc_nx[2*NBITS-1:NBITS];
          ovf   <= 1'b0;
          err   <= 1'b0;
        end
      end else
`endif
      if (start) begin
`ifdef ULA_MUL_EN
        if (f == 3'b011) begin
          state  <= S_MUL;
          mcand  <= {{NBITS{1'b0}}, a};
          mplier <= b;
          acc    <= '0;
          cnt    <= '0;
        end else
`endif
        begin
          state <= S_DONE;
          y     <= alu_y;
          zero  <= (alu_y == '0);
          neg   <= alu_y[MSB];
          carry <= alu_c;
          ovf   <= alu_o;
          err   <= alu_e;
        end
      end else begin
        state <= S_IDLE;
      end
    end
  end

endmodule
